// File: rtl/tmu_mem_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : tmu_pkg                                                   |
// | Desc     : Shared line geometry, types and responder state encoding. |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package tmu_pkg;

    localparam int LINE_BYTES     = 16;
    localparam int LINE_OFF       = 4;
    localparam int TMU_DATA_WIDTH = 64;

    typedef logic [2*TMU_DATA_WIDTH-1:0] line_t;
    typedef logic [LINE_BYTES-1:0]       bmask_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_t;

endpackage
`default_nettype wire

// File: rtl/tmu_mem_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : tmu_mem_responder_if                                     |
// | Desc      : TMU read request/response and loader write signals.      |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
interface tmu_mem_responder_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    import tmu_pkg::*;

    logic                    ren_mem;
    logic [ADDR_WIDTH-1:0]   raddr_mem;
    logic                    rvalid_mem;
    logic [2*DATA_WIDTH-1:0] rdata_mem;
    logic                    rerr_mem;
    logic                    busy;
    logic                    wen_ld;
    logic [ADDR_WIDTH-1:0]   waddr_ld;
    logic [2*DATA_WIDTH-1:0] wdata_ld;
    bmask_t                  wmask_ld;

    modport master (
        output ren_mem, raddr_mem, wen_ld, waddr_ld, wdata_ld, wmask_ld,
        input  rvalid_mem, rdata_mem, rerr_mem, busy
    );

    modport slave (
        input  ren_mem, raddr_mem, wen_ld, waddr_ld, wdata_ld, wmask_ld,
        output rvalid_mem, rdata_mem, rerr_mem, busy
    );

endinterface
`default_nettype wire

// File: rtl/tmu_mem_responder_line_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tmu_line_ram                                              |
// | Desc     : Line array, byte-masked write, registered read/clear port.|
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tmu_line_ram
    import tmu_pkg::*;
#(
    parameter int CAPACITY = 1024,
    parameter int LINE_W   = 128,
    parameter int IDX_W    = $clog2(CAPACITY)
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              we,
    input  wire logic [IDX_W-1:0]  widx,
    input  wire logic [LINE_W-1:0] wdata,
    input  wire bmask_t            wmask,
    input  wire logic              re,
    input  wire logic              clr,
    input  wire logic [IDX_W-1:0]  ridx,
    output logic      [LINE_W-1:0] rdata
);

    logic [LINE_W-1:0] r_mem [CAPACITY];
    logic [LINE_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < LINE_BYTES; b++) begin
                if (wmask[b]) begin
                    r_mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Both blocks update with NBAs, so a same-edge write is not seen by the read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (clr) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[ridx];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/tmu_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tmu_mem_responder                                         |
// | Desc     : Fixed-latency line responder for the TMU read protocol.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tmu_mem_responder
    import tmu_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int CAPACITY   = 1024,
    parameter int LATENCY    = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    tmu_mem_responder_if.slave bus
);

    localparam int c_IDX_W  = $clog2(CAPACITY);
    localparam int c_CNT_W  = $clog2(LATENCY + 1);
    localparam int c_TAG_LO = c_IDX_W + LINE_OFF;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 1);

    resp_state_t                  r_state, w_state_nxt;
    logic [c_CNT_W-1:0]           r_cnt, w_cnt_nxt;
    logic [ADDR_WIDTH-1:LINE_OFF] r_line, w_line_nxt;
    logic                         r_rvalid, w_rvalid_nxt;
    logic                         r_rerr, w_rerr_nxt;
    logic                         r_busy, w_busy_nxt;

    logic                         w_fire;
    logic [ADDR_WIDTH-1:LINE_OFF] w_sel_line;
    logic                         w_rd_oor;
    logic [c_IDX_W-1:0]           w_rd_idx;
    logic                         w_wr_en;
    logic [2*DATA_WIDTH-1:0]      w_ram_rdata;

    // With LATENCY==1 the array is read on the accepting edge, before the latch.
    assign w_sel_line = (r_state == IDLE) ? bus.raddr_mem[ADDR_WIDTH-1:LINE_OFF] : r_line;
    assign w_rd_oor   = |w_sel_line[ADDR_WIDTH-1:c_TAG_LO];
    assign w_rd_idx   = w_sel_line[c_TAG_LO-1:LINE_OFF];
    assign w_wr_en    = bus.wen_ld & ~(|bus.waddr_ld[ADDR_WIDTH-1:c_TAG_LO]);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_line_nxt   = r_line;
        w_busy_nxt   = r_busy;
        w_fire       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.ren_mem) begin
                    w_line_nxt = bus.raddr_mem[ADDR_WIDTH-1:LINE_OFF];
                    w_busy_nxt = 1'b1;
                    w_cnt_nxt  = c_CNT_LOAD;
                    if (LATENCY == 1) begin
                        w_fire      = 1'b1;
                        w_state_nxt = RESP;
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!bus.ren_mem) begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                end else begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                    if (r_cnt <= c_CNT_W'(1)) begin
                        w_fire      = 1'b1;
                        w_state_nxt = RESP;
                    end
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
                w_cnt_nxt   = '0;
            end
        endcase
        w_rvalid_nxt = w_fire;
        w_rerr_nxt   = w_fire & w_rd_oor;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_line   <= '0;
            r_rvalid <= 1'b0;
            r_rerr   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_line   <= w_line_nxt;
            r_rvalid <= w_rvalid_nxt;
            r_rerr   <= w_rerr_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    tmu_line_ram #(
        .CAPACITY (CAPACITY),
        .LINE_W   (2*DATA_WIDTH),
        .IDX_W    (c_IDX_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (w_wr_en),
        .widx  (bus.waddr_ld[c_TAG_LO-1:LINE_OFF]),
        .wdata (bus.wdata_ld),
        .wmask (bus.wmask_ld),
        .re    (w_fire & ~w_rd_oor),
        .clr   (w_fire & w_rd_oor),
        .ridx  (w_rd_idx),
        .rdata (w_ram_rdata)
    );

    assign bus.rvalid_mem = r_rvalid;
    assign bus.rerr_mem   = r_rerr;
    assign bus.busy       = r_busy;
    assign bus.rdata_mem  = w_ram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_tmu_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_tmu_mem_responder                                      |
// | Desc     : Directed + random bench against a cycle-arithmetic model. |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_tmu_mem_responder;
    import tmu_pkg::*;

    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int CAP = 1024;
    localparam int L   = 4;
    localparam int TAG_LO = $clog2(CAP) + 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tmu_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus  ();
    tmu_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

    tmu_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CAPACITY(CAP), .LATENCY(L))
        dut  (.clk(clk), .rst(rst), .bus(bus));
    tmu_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CAPACITY(CAP), .LATENCY(1))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model (edge arithmetic) ----------------
    line_t       shadow [int];
    bit          m_pend = 1'b0;
    int          m_a = 0, m_next_ok = 0, m_edge = 0;
    logic [63:0] m_paddr = '0;
    logic        m_rvalid = 1'b0, m_rerr = 1'b0, m_busy = 1'b0;
    line_t       m_rdata = '0;

    function automatic bit is_oor(input logic [63:0] a);
        return (a >> TAG_LO) != 64'd0;
    endfunction

    function automatic int line_of(input logic [63:0] a);
        return int'(a[TAG_LO-1:4]);
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_pend = 1'b0; m_rvalid = 1'b0; m_rerr = 1'b0; m_busy = 1'b0;
            m_rdata = '0; m_next_ok = 0;
        end else begin
            int e;
            line_t ln;
            e = m_edge;
            m_edge++;
            m_rvalid = 1'b0;
            m_rerr   = 1'b0;
            if (m_pend && e == m_a + L) m_pend = 1'b0;
            if (m_pend && e > m_a && e < m_a + L && !bus.ren_mem) begin
                m_pend = 1'b0;
                m_next_ok = e + 1;
            end
            if (!m_pend && e >= m_next_ok && bus.ren_mem) begin
                m_pend = 1'b1; m_a = e; m_paddr = bus.raddr_mem;
                m_next_ok = e + L + 1;
            end
            if (m_pend && e == m_a + L - 1) begin
                m_rvalid = 1'b1;
                if (is_oor(m_paddr)) begin
                    m_rerr = 1'b1; m_rdata = '0;
                end else begin
                    m_rdata = shadow[line_of(m_paddr)];
                end
            end
            m_busy = m_pend;
            // writes land after the response snapshot (read-before-write)
            if (bus.wen_ld && !is_oor(bus.waddr_ld)) begin
                ln = shadow.exists(line_of(bus.waddr_ld)) ? shadow[line_of(bus.waddr_ld)] : '0;
                for (int b = 0; b < 16; b++)
                    if (bus.wmask_ld[b]) ln[b*8 +: 8] = bus.wdata_ld[b*8 +: 8];
                shadow[line_of(bus.waddr_ld)] = ln;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            check("cyc_rvalid", bus.rvalid_mem, m_rvalid);
            check("cyc_busy",   bus.busy,       m_busy);
            check("cyc_rerr",   bus.rerr_mem,   m_rerr);
            check("cyc_rdata",  bus.rdata_mem,  m_rdata);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input logic [63:0] a, input line_t d, input bmask_t m);
        bus.wen_ld = 1'b1; bus.waddr_ld = a; bus.wdata_ld = d; bus.wmask_ld = m;
        tick();
        bus.wen_ld = 1'b0;
    endtask

    task automatic do_read(input logic [63:0] a, input int wcyc, input logic [63:0] wa,
                           input line_t wd, output int lat, output line_t d,
                           output logic e, output int at, output logic busy1);
        bus.ren_mem = 1'b1; bus.raddr_mem = a;
        lat = -1; d = '0; e = 1'b0; at = 0; busy1 = 1'b0;
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            tick();
            if (c == wcyc) begin
                bus.wen_ld = 1'b1; bus.waddr_ld = wa; bus.wdata_ld = wd; bus.wmask_ld = 16'hFFFF;
            end else begin
                bus.wen_ld = 1'b0;
            end
            @(negedge clk);
            if (c == 1) busy1 = bus.busy;
            if (bus.rvalid_mem) begin
                lat = c; d = bus.rdata_mem; e = bus.rerr_mem; at = cyc;
            end
        end
        tick();
        bus.ren_mem = 1'b0; bus.wen_ld = 1'b0;
    endtask

    function automatic logic [63:0] rand_addr();
        if ($urandom_range(0, 9) == 0)
            return (64'd1 << $urandom_range(TAG_LO, 63)) | 64'($urandom_range(0, 15));
        return (64'($urandom_range(0, 31)) << 4) | 64'($urandom_range(0, 15));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat, at1, at2;
        line_t d;
        logic e, b1, seen;

        bus.ren_mem = 1'b0; bus.raddr_mem = '0; bus.wen_ld = 1'b0;
        bus.waddr_ld = '0; bus.wdata_ld = '0; bus.wmask_ld = '0;
        bus1.ren_mem = 1'b0; bus1.raddr_mem = '0; bus1.wen_ld = 1'b0;
        bus1.waddr_ld = '0; bus1.wdata_ld = '0; bus1.wmask_ld = '0;
        rst = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset_rvalid", bus.rvalid_mem, 0);
        check("reset_busy",   bus.busy,       0);
        check("reset_rerr",   bus.rerr_mem,   0);
        check("reset_rdata",  bus.rdata_mem,  0);
        tick();
        chk_on = 1'b1;

        for (int i = 0; i < 32; i++)
            load(64'(i) << 4, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF);

        // basic read
        load(64'h20, 128'h00112233445566778899AABBCCDDEEFF, 16'hFFFF);
        do_read(64'h28, -1, '0, '0, lat, d, e, at1, b1);
        check("basic_latency", lat, L);
        check("basic_data", d, 128'h00112233445566778899AABBCCDDEEFF);
        check("basic_rerr", e, 0);
        check("basic_busy_c1", b1, 1);

        // masked write
        load(64'h50, {16{8'hAA}}, 16'hFFFF);
        load(64'h50, {16{8'h55}}, 16'h00FF);
        do_read(64'h50, -1, '0, '0, lat, d, e, at1, b1);
        check("masked_data", d, {{8{8'hAA}}, {8{8'h55}}});

        // abort: ren low in cycle 2
        bus.ren_mem = 1'b1; bus.raddr_mem = 64'h20;
        tick(); tick();
        bus.ren_mem = 1'b0;
        tick();
        @(negedge clk);
        check("abort_busy_c3", bus.busy, 0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin tick(); @(negedge clk); seen |= bus.rvalid_mem; end
        check("abort_no_rvalid", seen, 0);
        check("abort_rdata_kept", bus.rdata_mem, {{8{8'hAA}}, {8{8'h55}}});

        // out of range
        do_read(64'd1 << 14, -1, '0, '0, lat, d, e, at1, b1);
        check("oor_latency", lat, L);
        check("oor_rerr", e, 1);
        check("oor_data", d, 0);

        // collision on the edge entering RESP
        load(64'h70, {16{8'h07}}, 16'hFFFF);
        do_read(64'h70, L - 1, 64'h70, {16{8'hFF}}, lat, d, e, at1, b1);
        check("collide_old", d, {16{8'h07}});
        tick();
        do_read(64'h70, -1, '0, '0, lat, d, e, at1, b1);
        check("collide_reread", d, {16{8'hFF}});

        // reset in cycle 3 of a request
        bus.ren_mem = 1'b1; bus.raddr_mem = 64'h28;
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        check("rstmid_rvalid", bus.rvalid_mem, 0);
        check("rstmid_busy",   bus.busy,       0);
        check("rstmid_rerr",   bus.rerr_mem,   0);
        check("rstmid_rdata",  bus.rdata_mem,  0);
        bus.ren_mem = 1'b0;
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin tick(); @(negedge clk); seen |= bus.rvalid_mem; end
        check("rstmid_no_rvalid", seen, 0);

        // back-to-back, TMU-style
        do_read(64'h28, -1, '0, '0, lat, d, e, at1, b1);
        tick();
        do_read(64'h58, -1, '0, '0, lat, d, e, at2, b1);
        check("b2b_spacing", at2 - at1, L + 2);
        check("b2b_data", d, {{8{8'hAA}}, {8{8'h55}}});

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            bus.ren_mem = bus.ren_mem ? (r < 90) : (r < 40);
            if ($urandom_range(0, 3) == 0) bus.raddr_mem = rand_addr();
            rst = ($urandom_range(0, 199) == 0);
            bus.wen_ld   = !rst && ($urandom_range(0, 3) == 0);
            bus.waddr_ld = rand_addr();
            bus.wdata_ld = {$urandom, $urandom, $urandom, $urandom};
            bus.wmask_ld = 16'($urandom);
            tick();
        end
        rst = 1'b0; bus.ren_mem = 1'b0; bus.wen_ld = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        // LATENCY=1 variant
        bus1.wen_ld = 1'b1; bus1.waddr_ld = 64'h30;
        bus1.wdata_ld = 128'hCAFEF00D_12345678_9ABCDEF0_0BADBEEF; bus1.wmask_ld = 16'hFFFF;
        tick();
        bus1.wen_ld = 1'b0;
        bus1.ren_mem = 1'b1; bus1.raddr_mem = 64'h3C;
        tick();
        @(negedge clk);
        check("lat1_rvalid_c1", bus1.rvalid_mem, 1);
        check("lat1_busy_c1", bus1.busy, 1);
        check("lat1_data", bus1.rdata_mem, 128'hCAFEF00D_12345678_9ABCDEF0_0BADBEEF);
        tick();
        bus1.ren_mem = 1'b0;
        @(negedge clk);
        check("lat1_rvalid_c2", bus1.rvalid_mem, 0);
        tick();

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tmu_mem_responder.md
Name: tmu_mem_responder

Overview:
- Memory-side responder for the TMU read protocol: accepts a held read request `ren_mem`/`raddr_mem` and returns one 128-bit line `rdata_mem` with a one-cycle `rvalid_mem` pulse after a fixed latency.
- Backs a line-organised storage array; a loader write port fills it.
- Sits between the TMU (or any translation refill initiator) and memory; it is also the bench's memory model for TMU-level tests.

Parameters:
- ADDR_WIDTH, 64, byte-address width of `raddr_mem`/`waddr_ld`.
- DATA_WIDTH, 64, half-line width; one line is 2*DATA_WIDTH = 128 bits = 16 bytes.
- CAPACITY, 1024, number of 16-byte lines in the array (power of two, >=2).
- LATENCY, 4, cycles from request acceptance to `rvalid_mem` (>=1).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ren_mem` in 1: read request; the initiator holds it high until it samples `rvalid_mem`.
- `raddr_mem` in ADDR_WIDTH: read byte address, stable while `ren_mem` is high.
- `rvalid_mem` out 1: response valid, one-cycle pulse.
- `rdata_mem` out 2*DATA_WIDTH: response line.
- `rerr_mem` out 1: asserted with `rvalid_mem` when the address is out of range.
- `busy` out 1: high while a request is accepted and not yet responded.
- `wen_ld` in 1: loader write enable.
- `waddr_ld` in ADDR_WIDTH: loader byte address.
- `wdata_ld` in 2*DATA_WIDTH: loader line data.
- `wmask_ld` in 16: byte-enable mask for the loader write; bit i enables byte i.

Behaviour:
- Reset (async, `rst`=1):
  - state=IDLE.
  - `rvalid_mem`, `rerr_mem`, `busy` are 0; `rdata_mem` is 0; latency counter is 0.
  - Array contents are NOT reset.
- Line index:
  - idx = addr[$clog2(CAPACITY)+3:4]; addr[3:0] is ignored (line-aligned).
  - Out of range when addr[ADDR_WIDTH-1:$clog2(CAPACITY)+4] != 0.
- States:
  - IDLE:
    - On an edge with `ren_mem`=1: latch `raddr_mem`, set `busy`=1, load the counter, go to WAIT.
    - If LATENCY==1, go directly to RESP.
  - WAIT:
    - The counter decrements each edge.
    - When it expires: register `rdata_mem` = array[idx] (or 0 with `rerr_mem`=1 if out of range), set `rvalid_mem`=1, go to RESP.
  - RESP:
    - `rvalid_mem` is high for exactly this cycle.
    - Next edge: `rvalid_mem`=0, `rerr_mem`=0, `busy`=0, state=IDLE.
    - `ren_mem` is ignored on that edge.
    - `rdata_mem` holds its value until the next response.
- Latency: if `ren_mem` is first sampled high at the edge ending cycle 0, `rvalid_mem` is high in cycle LATENCY.
- Minimum spacing:
  - The next request is accepted no earlier than the edge ending cycle LATENCY+1.
  - A TMU re-asserting `ren_mem` immediately therefore sees the response at cycle LATENCY+2+LATENCY relative to the first request.
- Changes on `raddr_mem` while state!=IDLE are ignored; the latched address is used.
- Abort: if `ren_mem` falls while in WAIT, return to IDLE with `busy`=0, no `rvalid_mem`, and `rdata_mem` unchanged.
- Loader writes:
  - Accepted in any state on an edge with `wen_ld`=1.
  - Only masked bytes are written.
  - An out-of-range `waddr_ld` is dropped silently.
- Read/write collision: the array read for a response happens on the edge entering RESP; a loader write to the same line on that same edge is not visible (read-before-write). Writes on earlier edges are visible.
- Reset mid-operation: the pending request is discarded and outputs return to reset values immediately. The initiator must re-request.
- Counter width: $clog2(LATENCY+1), saturating at 0; it never wraps.

Decomposition:
- Shared package `tmu_pkg`:
  - LINE_BYTES=16 and LINE_OFF=4.
  - typedef `line_t` (logic [2*DATA_WIDTH-1:0]).
  - typedef `bmask_t` (logic [15:0]).
  - Responder state enum {IDLE, WAIT, RESP}.
- One sub-module, `tmu_line_ram`:
  - CAPACITY x 128 array with a byte-masked write port and a synchronous read port.
  - Holds the read-before-write rule; the FSM and counter stay in the top.

Test Plan:
- Basic read: load line 0x2 = 0x0011...EEFF via `waddr_ld`=0x20 with mask 0xFFFF; `ren_mem`=1, `raddr_mem`=0x28 -> `rvalid_mem` in cycle 4, `rdata_mem`=0x0011...EEFF, `rerr_mem`=0, `busy` 1 for cycles 1..4.
- Masked write: line 5 preloaded all 0xAA; write `wdata` all 0x55 with `wmask_ld`=0x00FF -> read 0x50 returns upper 8 bytes 0xAA, lower 8 bytes 0x55.
- Out of range: `raddr_mem`=1<<14 (CAPACITY=1024) -> `rvalid_mem` in cycle 4 with `rerr_mem`=1 and `rdata_mem`=0.
- Abort and reset: drop `ren_mem` in cycle 2 -> no `rvalid_mem`, `busy`=0 in cycle 3. Separately, assert `rst` in cycle 3 of a request -> all outputs 0 at once, no later `rvalid`.
- Collision: write line 7 with 0xFF... on the edge entering RESP of a line-7 read -> response shows old data; an immediate re-read shows 0xFF....
- Back-to-back with a TMU-style initiator (`ren` dropped the cycle after `rvalid`, re-raised next cycle) -> second `rvalid_mem` exactly LATENCY+2 cycles after the first; LATENCY=1 variant gives `rvalid` in cycle 1.
